// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, LSB first, 8N1 by default, timed by a 16x baud tick.
// Define TX_PARITY_EN to insert an even parity bit between the data and stop bits.
module uart_tx #(
    parameter int DBIT = 8,
    parameter int SB_TICK = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_tick,
    input  logic            i_tx_start,
    input  logic [DBIT-1:0] i_tx_data,
    output logic            o_tx,
    output logic            o_tx_busy,
    output logic            o_tx_done_tick
);
    localparam int SW = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
    localparam int NW = $clog2(DBIT);
`ifdef TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic p_q;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            bit_end;
    assign bit_end   = i_tick && s_q == SW'(OVERSAMPLE - 1);
    assign o_tx      = tx_q;
    assign o_tx_busy = state_q != IDLE;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end
`ifdef TX_PARITY_EN
    always_ff @(posedge i_clk) begin
        if (i_rst)
            p_q <= 1'b0;
        else if (state_q == IDLE && i_tx_start)
            p_q <= ^i_tx_data;
    end
`endif
    always_comb begin
        state_d        = state_q;
        s_d            = s_q;
        n_d            = n_q;
        b_d            = b_q;
        o_tx_done_tick = 1'b0;
        case (state_q)
            IDLE: if (i_tx_start) begin
                state_d = START;
                s_d     = '0;
                n_d     = '0;
                b_d     = i_tx_data;
            end
            START: if (i_tick) begin
                s_d = bit_end ? '0 : s_q + 1'b1;
                if (bit_end) state_d = DATA;
            end
            DATA: if (i_tick) begin
                s_d = bit_end ? '0 : s_q + 1'b1;
                if (bit_end) begin
                    b_d = b_q >> 1;
                    if (n_q == NW'(DBIT - 1))
`ifdef TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    else
                        n_d = n_q + 1'b1;
                end
            end
`ifdef TX_PARITY_EN
            PARITY: if (i_tick) begin
                s_d = bit_end ? '0 : s_q + 1'b1;
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: if (i_tick) begin
                if (s_q == SW'(SB_TICK - 1)) begin
                    state_d        = IDLE;
                    s_d            = '0;
                    o_tx_done_tick = 1'b1;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Line level follows the next state so o_tx can come straight from a flop.
`ifdef TX_PARITY_EN
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? b_d[0] : state_d == PARITY ? p_q : 1'b1;
`else
        tx_d = state_d == START ? 1'b0 : state_d == DATA ? b_d[0] : 1'b1;
`endif
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a tick-counting reference receiver.
// Honours TX_PARITY_EN to expect the extra parity bit.
module tb_uart_tx;
    localparam int DBIT = 8;
    localparam int OS = 16;
    localparam int SB = 16;
`ifdef TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int F = (1 + DBIT + PB) * OS + SB;

    logic clk = 1'b0, i_rst = 1'b1, i_tick = 1'b0, i_tx_start = 1'b0;
    logic [DBIT-1:0] i_tx_data = '0;
    logic o_tx, o_tx_busy, o_tx_done_tick;
    int tests = 0, fails = 0, div = 0;
    int res_line_err, res_busy_err, res_done_cnt, res_done_at, res_ticks;
    logic res_acc_busy, res_acc_tx, res_par;
    logic [7:0] res_rx;

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB), .OVERSAMPLE(OS)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_tick(i_tick), .i_tx_start(i_tx_start),
        .i_tx_data(i_tx_data), .o_tx(o_tx), .o_tx_busy(o_tx_busy), .o_tx_done_tick(o_tx_done_tick)
    );

    initial forever #5 clk = ~clk;

    // One clock: inputs change on the falling edge, outputs sampled 1 ns later.
    task automatic step(input logic st, input logic [7:0] d, input logic r);
        @(negedge clk);
        div = (div + 1) % 4;
        i_tick = (div == 0);
        i_tx_start = st;
        i_tx_data = d;
        i_rst = r;
        #1;
    endtask

    // Expected line level during the t-th tick after acceptance (t counts from 1).
    function automatic logic exp_line(int t, logic [7:0] d);
        int idx = (t - 1) / OS;
        if (idx == 0) return 1'b0;
        if (idx <= DBIT) return d[idx-1];
        if (PB == 1 && idx == DBIT + 1) return ^d;
        return 1'b1;
    endfunction

    task automatic send_frame(input logic [7:0] d, input int inj_tick, input logic [7:0] inj_d, input int rst_tick);
        int k = 0;
        logic injected = 1'b0, inj;
        res_line_err = 0; res_busy_err = 0; res_done_cnt = 0; res_done_at = -1; res_rx = '0; res_par = 1'bx;
        step(1'b1, d, 1'b0);
        res_acc_busy = o_tx_busy;
        res_acc_tx = o_tx;
        for (int c = 0; c < 4000 && k < F; c++) begin
            if (rst_tick > 0 && k == rst_tick) begin
                step(1'b0, 8'($urandom), 1'b1);
                res_ticks = k;
                return;
            end
            inj = inj_tick > 0 && k == inj_tick && !injected;
            if (inj) injected = 1'b1;
            step(inj, inj ? inj_d : 8'($urandom), 1'b0);
            if (o_tx !== exp_line(k + 1, d)) res_line_err++;
            if (o_tx_busy !== 1'b1) res_busy_err++;
            if (o_tx_done_tick === 1'b1) begin
                res_done_cnt++;
                res_done_at = i_tick ? k + 1 : -1;
            end
            if (i_tick && k % OS == OS / 2 && k / OS >= 1 && k / OS <= DBIT) res_rx[k/OS-1] = o_tx;
            if (i_tick && k == (1 + DBIT) * OS + OS / 2) res_par = o_tx;
            if (i_tick) k++;
        end
        res_ticks = k;
    endtask

    task automatic test_reset();
        int bad = 0, ticks = 0;
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        tests++; if (o_tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", o_tx); end
        tests++; if (o_tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", o_tx_busy); end
        tests++; if (o_tx_done_tick !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", o_tx_done_tick); end
        for (int c = 0; c < 400 && ticks < 50; c++) begin
            step(1'b0, 8'($urandom), 1'b0);
            if (i_tick) ticks++;
            if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done_tick !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_single();
        send_frame(8'h02, 0, 8'h00, 0);
        tests++; if (res_acc_tx !== 1'b1) begin fails++; $display("FAIL single_acc_tx: got %b expected 1", res_acc_tx); end
        tests++; if (res_line_err !== 0) begin fails++; $display("FAIL single_line: got %0d bad cycles expected 0", res_line_err); end
        tests++; if (res_busy_err !== 0) begin fails++; $display("FAIL single_busy: got %0d bad cycles expected 0", res_busy_err); end
        tests++; if (res_done_cnt !== 1) begin fails++; $display("FAIL single_done_cnt: got %0d expected 1", res_done_cnt); end
        tests++; if (res_done_at !== F) begin fails++; $display("FAIL single_done_at: got %0d expected %0d", res_done_at, F); end
        tests++; if (res_rx !== 8'h02) begin fails++; $display("FAIL single_rx: got %h expected 02", res_rx); end
        step(1'b0, 8'($urandom), 1'b0);
        tests++; if (o_tx_busy !== 1'b0 || o_tx_done_tick !== 1'b0 || o_tx !== 1'b1) begin
            fails++; $display("FAIL single_after: got busy=%b done=%b tx=%b expected 0 0 1", o_tx_busy, o_tx_done_tick, o_tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rx1;
        int err1, done1;
        send_frame(8'h03, 0, 8'h00, 0);
        rx1 = res_rx; err1 = res_line_err + res_busy_err; done1 = res_done_at;
        send_frame(8'h02, 0, 8'h00, 0);
        tests++; if (rx1 !== 8'h03) begin fails++; $display("FAIL b2b_rx1: got %h expected 03", rx1); end
        tests++; if (err1 !== 0 || done1 !== F) begin fails++; $display("FAIL b2b_frame1: got err=%0d done_at=%0d expected 0 %0d", err1, done1, F); end
        tests++; if (res_acc_busy !== 1'b0) begin fails++; $display("FAIL b2b_accept: got busy=%b expected 0", res_acc_busy); end
        tests++; if (res_rx !== 8'h02) begin fails++; $display("FAIL b2b_rx2: got %h expected 02", res_rx); end
        tests++; if (res_line_err + res_busy_err !== 0 || res_done_at !== F) begin
            fails++; $display("FAIL b2b_frame2: got err=%0d done_at=%0d expected 0 %0d", res_line_err + res_busy_err, res_done_at, F);
        end
    endtask

    task automatic test_start_during_frame();
        int bad = 0;
        send_frame(8'hA5, 40, 8'hFF, 0);
        tests++; if (res_rx !== 8'hA5) begin fails++; $display("FAIL busy_start_rx: got %h expected a5", res_rx); end
        tests++; if (res_line_err !== 0) begin fails++; $display("FAIL busy_start_line: got %0d bad cycles expected 0", res_line_err); end
        tests++; if (res_done_cnt !== 1) begin fails++; $display("FAIL busy_start_done: got %0d expected 1", res_done_cnt); end
        for (int c = 0; c < 200; c++) begin
            step(1'b0, 8'($urandom), 1'b0);
            if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done_tick !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL busy_start_after: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        send_frame(8'h55, 0, 8'h00, 70);
        step(1'b0, 8'($urandom), 1'b0);
        tests++; if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done_tick !== 1'b0) begin
            fails++; $display("FAIL midrst_state: got tx=%b busy=%b done=%b expected 1 0 0", o_tx, o_tx_busy, o_tx_done_tick);
        end
        for (int c = 0; c < 200; c++) begin
            step(1'b0, 8'($urandom), 1'b0);
            if (o_tx !== 1'b1 || o_tx_busy !== 1'b0 || o_tx_done_tick !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL midrst_quiet: got %0d bad cycles expected 0", bad); end
        send_frame(8'h0F, 0, 8'h00, 0);
        tests++; if (res_rx !== 8'h0F || res_line_err !== 0) begin
            fails++; $display("FAIL midrst_resend: got rx=%h err=%0d expected 0f 0", res_rx, res_line_err);
        end
        tests++; if (res_done_at !== F || res_done_cnt !== 1) begin
            fails++; $display("FAIL midrst_done: got at=%0d cnt=%0d expected %0d 1", res_done_at, res_done_cnt, F);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            send_frame(d, 0, 8'h00, 0);
            tests++; if (res_rx !== d || res_line_err !== 0 || res_busy_err !== 0 || res_done_at !== F) begin
                fails++; $display("FAIL random_%0d: got rx=%h err=%0d/%0d done_at=%0d expected %h 0/0 %0d",
                                  i, res_rx, res_line_err, res_busy_err, res_done_at, d, F);
            end
            repeat ($urandom_range(0, 3)) step(1'b0, 8'($urandom), 1'b0);
        end
    endtask

`ifdef TX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 0, 8'h00, 0);
        tests++; if (res_par !== 1'b1) begin fails++; $display("FAIL parity_07: got %b expected 1", res_par); end
        tests++; if (res_done_at !== 176 || res_line_err !== 0) begin
            fails++; $display("FAIL parity_len: got done_at=%0d err=%0d expected 176 0", res_done_at, res_line_err);
        end
        send_frame(8'h03, 0, 8'h00, 0);
        tests++; if (res_par !== 1'b0) begin fails++; $display("FAIL parity_03: got %b expected 0", res_par); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_start_during_frame();
        test_reset_mid();
        test_random();
`ifdef TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter serializing one byte per request onto the serial line, 8N1 by default, LSB first.
Sits downstream of uart_to_alu_to_uart: consumes its tx_start/tx_data pulse-and-byte output and drives the board TX pin.
Timing comes from the shared baud-rate generator tick (16x oversampling), the same tick used by the receiver path.
Reports frame completion with a one-cycle done tick so the upstream FSM can sequence further bytes.

Parameters:
DBIT, 8, number of data bits per frame (legal range 5..8).
SB_TICK, 16, baud ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
OVERSAMPLE, 16, baud ticks per start/data/parity bit.

Ports:
i_clk  input  1  system clock; single clock domain.
i_rst  input  1  reset, synchronous, active-high.
i_tick  input  1  baud tick; one-cycle pulse, OVERSAMPLE per bit period.
i_tx_start  input  1  one-cycle request to send i_tx_data.
i_tx_data  input  DBIT  byte to send; sampled only in the cycle the request is accepted.
o_tx  output  1  serial line; registered; idles high.
o_tx_busy  output  1  high while a frame is in progress.
o_tx_done_tick  output  1  one-cycle pulse at end of stop bit.

Behaviour:
- Reset, synchronous on i_clk with i_rst high: state IDLE, o_tx=1, o_tx_busy=0, o_tx_done_tick=0, tick counter s=0, bit counter n=0, shift register=0.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE: o_tx=1. If i_tx_start=1, latch i_tx_data into the shift register, set s=0 and n=0, go to START. A tick in the acceptance cycle is not counted.
- START: o_tx=0 from the cycle after acceptance. On each i_tick, s increments. On the tick where s==OVERSAMPLE-1, set s=0 and go to DATA.
- DATA: o_tx = shift register bit 0. On the tick where s==OVERSAMPLE-1:
  - shift right, set s=0;
  - if n==DBIT-1, go to STOP (or PARITY when the feature is enabled);
  - otherwise increment n.
- STOP: o_tx=1. On the tick where s==SB_TICK-1, go to IDLE and assert o_tx_done_tick for exactly that one cycle.
- o_tx_busy = (state != IDLE), registered with the state. It is high from the cycle after acceptance through the o_tx_done_tick cycle inclusive.
- Frame length: (1+DBIT)*OVERSAMPLE + SB_TICK ticks; 160 ticks for defaults.
- i_tx_start while busy (any state other than IDLE) is ignored: data is not latched and the frame is unaffected.
- i_tx_start in the o_tx_done_tick cycle is also ignored, since the state is still STOP. The earliest accepted back-to-back request is the cycle after done; the start bit then begins the following cycle.
- i_tx_data changes after acceptance have no effect.
- Reset mid-frame: next cycle o_tx=1, IDLE, no done tick. The truncated frame is not resumed.
- Ticks arriving in IDLE are ignored; s stays 0.
- o_tx is driven from a register, with no combinational path from inputs.

Optional Feature:
Macro TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP. o_tx = even parity (XOR of all DBIT data bits) for OVERSAMPLE ticks. Frame length grows by OVERSAMPLE ticks (176 for defaults).
- Not defined: no PARITY state and no parity logic; the frame is plain 8N1.

Test Plan:
- Idle/reset: assert i_rst for 3 cycles, then run 50 ticks with no start -> o_tx=1, o_tx_busy=0, o_tx_done_tick never high.
- Single byte 0x02, i_tick every 4 clocks:
  - o_tx reads 0 (start), then bits 0,1,0,0,0,0,0,0, then 1 (stop);
  - each bit lasts 16 ticks;
  - o_tx_done_tick is high for exactly 1 cycle after tick 160;
  - o_tx_busy falls with it.
- Result byte 0x03 (ALU ADD of 2+1) followed immediately by 0x02 (SUB of 7-5), each issued the cycle after the previous done tick -> two contiguous frames, no idle gap beyond 1 clock, bits decoded by a bench UART receiver match.
- Start during frame: send 0xA5, then pulse i_tx_start with 0xFF at tick 40 -> the line carries only 0xA5 and one done tick; 0xFF is never transmitted.
- Reset mid-frame: send 0x55, assert i_rst at tick 70 -> o_tx=1 next cycle, busy=0, no done tick. A new 0x0F sent afterwards transmits correctly.
- With TX_PARITY_EN: send 0x07 -> parity bit 1 after the data bits, and the frame is 176 ticks. Send 0x03 -> parity bit 0.
